// File: rtl/riscv_pkg.sv
// Shared decode-stage definitions: immediate format codes and the combinational
// immediate extractor used by the registered immediate generator.
package riscv_pkg;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_J   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_Z   = 3'b101;
    localparam logic [2:0] IMM_SH  = 3'b110;
    localparam logic [2:0] IMM_RSV = 3'b111;

    localparam int XLEN_DEFAULT = 32;

    // Always produces a 64-bit result; callers keep the low XLEN bits, which is
    // exact because every format is sign- or zero-extended all the way to bit 63.
    function automatic logic [63:0] imm_decode(input logic [31:7] instr,
                                               input logic [2:0]  imm_src,
                                               input int          xlen);
        logic [63:0] imm;
        imm = '0;
        case (imm_src)
            IMM_I:   imm = {{52{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            IMM_Z:   imm = {59'b0, instr[19:15]};
            IMM_SH:  imm = (xlen == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/pipe_skid.sv
// Generic valid/ready pipeline register with a one-entry skid buffer; the
// upstream ready is a flop so no combinational path crosses the stage.
module pipe_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         ready_q;
    logic         accept;

    assign accept = in_valid && ready_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || out_ready) begin
            // Output slot frees up: the older skid entry has priority over new input.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_data_d = in_data;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= !skid_valid_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with sideband tag and valid/ready
// handshake; sits between the decode register and the execute operand mux.
module imm_gen_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 8,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:7]      Instr,
    input  logic [2:0]       ImmSrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ImmExt,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
);

    localparam int W = XLEN + TAG_W + 1;

    logic [XLEN-1:0] imm_d;
    logic [W-1:0]    stage_d;
    logic [W-1:0]    stage_q;

    assign imm_d   = XLEN'(imm_decode(Instr, ImmSrc, XLEN));
    assign stage_d = {(ImmSrc == IMM_RSV), in_tag, imm_d};

    generate
        if (SKID == 1) begin : g_skid
            pipe_skid #(.W(W)) u_pipe_skid (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid),
                .in_ready  (in_ready),
                .in_data   (stage_d),
                .out_valid (out_valid),
                .out_ready (out_ready),
                .out_data  (stage_q)
            );
        end else begin : g_reg
            logic valid_q;
            logic [W-1:0] data_q;

            // Ready looks through the register: a draining output frees it this cycle.
            assign in_ready = out_ready || !valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else if (in_ready) begin
                    valid_q <= in_valid;
                    if (in_valid) begin
                        data_q <= stage_d;
                    end
                end
            end

            assign out_valid = valid_q;
            assign stage_q   = data_q;
        end
    endgenerate

    assign {illegal, out_tag, ImmExt} = stage_q;

endmodule
